// File: rtl/arm_id_control.sv
// ID-stage front end: IF/ID instruction latch, PC+4 adder, control decoder and hazard bubble mux.
// Optional CU_MUX_CLEAR_AM_EN: the bubble also forces addressing_mode to 00.
module arm_id_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_id_enable,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_current,
    input  logic        hazard_select,
    output logic [31:0] pc_plus_4,
    output logic [31:0] instruction_out,
    output logic        reg_write_enable,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic        mem_to_reg_select,
    output logic        alu_source_select,
    output logic        status_bit,
    output logic [3:0]  alu_operation,
    output logic        pc_source_select,
    output logic        mem_size,
    output logic [1:0]  addressing_mode
);

    typedef struct packed {
        logic       reg_write_enable;
        logic       mem_enable;
        logic       mem_rw;
        logic       mem_to_reg_select;
        logic       alu_source_select;
        logic       status_bit;
        logic [3:0] alu_operation;
        logic       pc_source_select;
        logic       mem_size;
        logic [1:0] addressing_mode;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    logic [31:0] instr_q;
    ctrl_t       dec;
    ctrl_t       muxed;

    logic        is_nop;
    logic        is_data_proc;
    logic        is_load_store;
    logic        is_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if (if_id_enable) begin
            instr_q <= instruction_in;
        end
    end

    assign instruction_out = instr_q;
    assign pc_plus_4       = pc_current + 32'd4;

    assign is_nop        = (instr_q == 32'd0);
    assign is_data_proc  = !is_nop && (instr_q[27:26] == 2'b00);
    assign is_load_store = (instr_q[27:26] == 2'b01);
    assign is_branch     = (instr_q[27:25] == 3'b101);

    // The cond field [31:28] is deliberately ignored; condition checking happens downstream.
    always_comb begin
        dec = '0;
        if (is_data_proc) begin
            dec.alu_operation     = instr_q[24:21];
            dec.status_bit        = instr_q[20];
            dec.alu_source_select = instr_q[25];
            dec.reg_write_enable  = (instr_q[24:23] != 2'b10);
            if (instr_q[25]) begin
                dec.addressing_mode = 2'b00;
            end else if (!instr_q[4]) begin
                dec.addressing_mode = 2'b01;
            end else begin
                dec.addressing_mode = 2'b10;
            end
        end else if (is_load_store) begin
            dec.mem_enable        = 1'b1;
            dec.mem_rw            = !instr_q[20];
            dec.mem_to_reg_select = instr_q[20];
            dec.reg_write_enable  = instr_q[20];
            dec.mem_size          = instr_q[22];
            dec.alu_operation     = instr_q[23] ? ALU_ADD : ALU_SUB;
            dec.alu_source_select = !instr_q[25];
            if (!instr_q[25]) begin
                dec.addressing_mode = 2'b00;
            end else if (instr_q[11:4] == 8'd0) begin
                dec.addressing_mode = 2'b01;
            end else begin
                dec.addressing_mode = 2'b10;
            end
        end else if (is_branch) begin
            dec.pc_source_select  = 1'b1;
            dec.reg_write_enable  = instr_q[24];
            dec.alu_operation     = ALU_ADD;
            dec.alu_source_select = 1'b1;
            dec.addressing_mode   = 2'b11;
        end
    end

    always_comb begin
        muxed = dec;
        if (hazard_select) begin
            muxed = '0;
`ifdef CU_MUX_CLEAR_AM_EN
            muxed.addressing_mode = 2'b00;
`else
            muxed.addressing_mode = dec.addressing_mode;
`endif
        end
    end

    assign reg_write_enable  = muxed.reg_write_enable;
    assign mem_enable        = muxed.mem_enable;
    assign mem_rw            = muxed.mem_rw;
    assign mem_to_reg_select = muxed.mem_to_reg_select;
    assign alu_source_select = muxed.alu_source_select;
    assign status_bit        = muxed.status_bit;
    assign alu_operation     = muxed.alu_operation;
    assign pc_source_select  = muxed.pc_source_select;
    assign mem_size          = muxed.mem_size;
    assign addressing_mode   = muxed.addressing_mode;

endmodule

// File: tb/tb_arm_id_control.sv
// Self-checking bench for arm_id_control: directed decode vectors, bubble/hold cases, randomized traffic vs a reference model.
module tb_arm_id_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_id_enable = 1'b0;
    logic [31:0] instruction_in = '0;
    logic [31:0] pc_current = '0;
    logic        hazard_select = 1'b0;
    logic [31:0] pc_plus_4;
    logic [31:0] instruction_out;
    logic        reg_write_enable, mem_enable, mem_rw, mem_to_reg_select;
    logic        alu_source_select, status_bit, pc_source_select, mem_size;
    logic [3:0]  alu_operation;
    logic [1:0]  addressing_mode;
    logic [13:0] ctrl;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_instr = '0;

    arm_id_control dut (
        .clk(clk), .reset(reset), .if_id_enable(if_id_enable),
        .instruction_in(instruction_in), .pc_current(pc_current),
        .hazard_select(hazard_select), .pc_plus_4(pc_plus_4),
        .instruction_out(instruction_out), .reg_write_enable(reg_write_enable),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_to_reg_select(mem_to_reg_select),
        .alu_source_select(alu_source_select), .status_bit(status_bit),
        .alu_operation(alu_operation), .pc_source_select(pc_source_select),
        .mem_size(mem_size), .addressing_mode(addressing_mode)
    );

    always #5 clk = ~clk;

    assign ctrl = {reg_write_enable, mem_enable, mem_rw, mem_to_reg_select, alu_source_select,
                   status_bit, alu_operation, pc_source_select, mem_size, addressing_mode};

    // Reference decoder: classify the word, fill named fields, then apply the bubble.
    function automatic logic [13:0] model(input logic [31:0] w, input logic hz);
        logic rwe = 0, me = 0, mrw = 0, m2r = 0, asrc = 0, sb = 0, pcs = 0, msz = 0;
        logic [3:0] alu = 0;
        logic [1:0] am = 0;
        logic i = w[25], l = w[20], u = w[23], b = w[22];
        int opcode = int'(w[24:21]);
        if (w == 0) begin
        end else if (w[27:26] == 2'd0) begin
            alu = w[24:21]; sb = w[20]; asrc = i;
            rwe = !(opcode >= 8 && opcode <= 11);
            am = i ? 2'd0 : (w[4] ? 2'd2 : 2'd1);
        end else if (w[27:26] == 2'd1) begin
            me = 1; mrw = !l; m2r = l; rwe = l; msz = b;
            alu = u ? 4'd4 : 4'd2; asrc = !i;
            am = !i ? 2'd0 : ((w[11:4] == 0) ? 2'd1 : 2'd2);
        end else if (w[27:25] == 3'd5) begin
            pcs = 1; rwe = w[24]; alu = 4'd4; asrc = 1; am = 2'd3;
        end
        if (hz) begin
            {rwe, me, mrw, m2r, asrc, sb, pcs, msz} = '0;
            alu = 0;
`ifdef CU_MUX_CLEAR_AM_EN
            am = 0;
`endif
        end
        return {rwe, me, mrw, m2r, asrc, sb, alu, pcs, msz, am};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset && if_id_enable) model_instr = instruction_in;
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        instruction_in = w;
        if_id_enable = 1'b1;
        tick();
        if_id_enable = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        pc_current = 32'd0;
        instruction_in = 32'hE2110000;
        if_id_enable = 1'b1;
        #1;
        checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instruction_out, 32'd0); end
        checks++; if (ctrl !== 14'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", ctrl, 14'd0); end
        checks++; if (pc_plus_4 !== 32'd4) begin errors++; $display("FAIL reset_pc4: got %h expected %h", pc_plus_4, 32'd4); end
        tick();
        checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_overrides_enable: got %h expected %h", instruction_out, 32'd0); end
        pc_current = 32'hFFFFFFFC;
        #1;
        checks++; if (pc_plus_4 !== 32'd0) begin errors++; $display("FAIL pc4_wrap: got %h expected %h", pc_plus_4, 32'd0); end
        reset = 1'b0;
        model_instr = '0;
        tick();
        checks++; if (instruction_out !== 32'hE2110000) begin errors++; $display("FAIL first_capture: got %h expected %h", instruction_out, 32'hE2110000); end
        // async clear between edges
        reset = 1'b1;
        #1;
        model_instr = '0;
        checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL async_clear: got %h expected %h", instruction_out, 32'd0); end
        reset = 1'b0;
        if_id_enable = 1'b0;
        #1;
    endtask

    task automatic test_decode_directed();
        logic [31:0] words [6];
        logic [13:0] exp   [6];
        words[0] = 32'hE2110000; exp[0] = 14'b1_0_0_0_1_1_0000_0_0_00;
        words[1] = 32'hE7D12000; exp[1] = 14'b1_1_0_1_0_0_0100_0_1_01;
        words[2] = 32'hE58A5000; exp[2] = 14'b0_1_1_0_1_0_0100_0_0_00;
        words[3] = 32'hDB000009; exp[3] = 14'b1_0_0_0_1_0_0100_1_0_11;
        words[4] = 32'h1AFFFFFD; exp[4] = 14'b0_0_0_0_1_0_0100_1_0_11;
        words[5] = 32'hE0805183; exp[5] = 14'b1_0_0_0_0_0_0100_0_0_01;
        hazard_select = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load(words[k]);
            checks++; if (instruction_out !== words[k]) begin errors++; $display("FAIL dir_latch[%0d]: got %h expected %h", k, instruction_out, words[k]); end
            checks++; if (ctrl !== exp[k]) begin errors++; $display("FAIL dir_ctrl[%0d]: got %b expected %b", k, ctrl, exp[k]); end
        end
    endtask

    task automatic test_bubble();
        logic [13:0] exp_bub;
`ifdef CU_MUX_CLEAR_AM_EN
        exp_bub = 14'b0;
`else
        exp_bub = 14'b0_0_0_0_0_0_0000_0_0_01;
`endif
        hazard_select = 1'b0;
        load(32'hE0805183);
        hazard_select = 1'b1;
        #1;
        checks++; if (ctrl !== exp_bub) begin errors++; $display("FAIL bubble_ctrl: got %b expected %b", ctrl, exp_bub); end
        instruction_in = 32'hE58A5000;
        if_id_enable = 1'b0;
        tick();
        checks++; if (instruction_out !== 32'hE0805183) begin errors++; $display("FAIL hold: got %h expected %h", instruction_out, 32'hE0805183); end
        if_id_enable = 1'b1;
        tick();
        if_id_enable = 1'b0;
        checks++; if (instruction_out !== 32'hE58A5000) begin errors++; $display("FAIL bubble_still_loads: got %h expected %h", instruction_out, 32'hE58A5000); end
        checks++; if (ctrl !== model(32'hE58A5000, 1'b1)) begin errors++; $display("FAIL bubble_ctrl_str: got %b expected %b", ctrl, model(32'hE58A5000, 1'b1)); end
        hazard_select = 1'b0;
        #1;
        checks++; if (ctrl !== 14'b0_1_1_0_1_0_0100_0_0_00) begin errors++; $display("FAIL bubble_release: got %b expected %b", ctrl, 14'b0_1_1_0_1_0_0100_0_0_00); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0: w[27:26] = 2'b00;
                1: w[27:26] = 2'b01;
                2: w[27:25] = 3'b101;
                3: w = 32'd0;
                4: w[27:25] = 3'b100;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) w[11:4] = 8'd0;
            instruction_in = w;
            if_id_enable = ($urandom_range(0, 3) != 0);
            hazard_select = ($urandom_range(0, 3) == 0);
            pc_current = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            #1;
            checks++; if (ctrl !== model(model_instr, hazard_select)) begin errors++; $display("FAIL rand_ctrl[%0d]: instr %h hz %b got %b expected %b", n, model_instr, hazard_select, ctrl, model(model_instr, hazard_select)); end
            checks++; if (pc_plus_4 !== pc_current + 32'd4) begin errors++; $display("FAIL rand_pc4[%0d]: got %h expected %h", n, pc_plus_4, pc_current + 32'd4); end
            tick();
            checks++; if (instruction_out !== model_instr) begin errors++; $display("FAIL rand_latch[%0d]: got %h expected %h", n, instruction_out, model_instr); end
        end
        if_id_enable = 1'b0;
        hazard_select = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_id_control.md
# arm_id_control

Instruction-decode front end for the 5-stage ARM pipeline. It holds the IF/ID instruction latch and computes the sequential PC (PC+4). It decodes the latched instruction into pipeline control signals and passes them through a hazard bubble mux before they enter the ID/EX register. The block has one clocked element, the instruction latch; the adder, decoder and mux are combinational.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  system clock; the latch updates on the rising edge
- reset  in  1  asynchronous, active-high; clears the instruction latch
- if_id_enable  in  1  1 = load instruction_in on the clock edge; 0 = hold
- instruction_in  in  32  instruction read from instruction memory
- pc_current  in  32  current PC value
- hazard_select  in  1  1 = force a bubble (zero all muxed controls)
- pc_plus_4  out  32  pc_current + 4
- instruction_out  out  32  latched instruction (the ID-stage instruction)
- reg_write_enable  out  1  register file write
- mem_enable  out  1  data memory access
- mem_rw  out  1  1 = write (store), 0 = read
- mem_to_reg_select  out  1  write-back from memory (load)
- alu_source_select  out  1  1 = immediate second operand
- status_bit  out  1  update the flags
- alu_operation  out  4  ALU opcode
- pc_source_select  out  1  branch taken (B/BL)
- mem_size  out  1  1 = byte, 0 = word
- addressing_mode  out  2  addressing-mode code

## Operation
- **Adder:** pc_plus_4 = pc_current + 4, modulo 2^32 (wraps, no carry out).
- **Latch:** loads instruction_in when if_id_enable = 1; otherwise holds its value.
- **Decode** uses the latched word. The cond field is not evaluated here.
  - All-zero word = NOP: every control output is 0.
- **Data processing** (bits[27:26] = 00, excluding the all-zero word):
  - alu_operation = bits[24:21]; status_bit = bit20; alu_source_select = bit25 (I).
  - reg_write_enable = 1, except opcodes 10xx (TST/TEQ/CMP/CMN), which give 0.
  - addressing_mode: 00 if I = 1; 01 if I = 0 and bit4 = 0; 10 if I = 0 and bit4 = 1.
- **Load/store** (bits[27:26] = 01):
  - mem_enable = 1; mem_rw = !L (bit20); mem_to_reg_select = L; reg_write_enable = L; mem_size = B (bit22).
  - alu_operation = 0100 if U = 1, 0010 if U = 0; alu_source_select = !I (bit25); status_bit = 0.
  - addressing_mode: 00 if I = 0 (immediate offset); 01 if I = 1 and bits[11:4] = 0 (register offset); 10 otherwise (scaled register).
- **Branch** (bits[27:25] = 101):
  - pc_source_select = 1; reg_write_enable = L (bit24); alu_operation = 0100; alu_source_select = 1; addressing_mode = 11.
  - All memory controls = 0.
- **Any other encoding:** all controls 0.
- **Bubble mux:** when hazard_select = 1, all muxed outputs are 0. Muxed outputs: reg_write_enable, mem_enable, mem_rw, mem_to_reg_select, alu_source_select, status_bit, alu_operation, pc_source_select, mem_size. addressing_mode is not muxed (see Configuration).

## Timing
- **Reset:** instruction_out = 0 immediately, so every control output is 0. pc_plus_4 still follows pc_current.
- **Instruction latency:** instruction_in is visible on instruction_out one rising edge after capture.
- **Control outputs:** valid combinationally in the same cycle from instruction_out and hazard_select, with zero added latency.
- **Reset during operation:** clears the latch asynchronously and overrides if_id_enable.
- **Reset release:** the first capture happens on the next rising edge with if_id_enable = 1.
- **Simultaneous events:** hazard_select = 1 together with if_id_enable = 1 still loads the latch; only the controls are zeroed.

## Configuration
- **CU_MUX_CLEAR_AM_EN defined:** hazard_select = 1 also forces addressing_mode to 00.
- **CU_MUX_CLEAR_AM_EN undefined (default):** addressing_mode always reflects the decoded instruction, regardless of hazard_select.

## Test plan
- Reset with pc_current = 0 -> instruction_out = 0, all controls 0, pc_plus_4 = 4. Separately, pc_current = 0xFFFFFFFC -> pc_plus_4 = 0.
- Latch 0xE2110000 (ANDS imm) -> reg_write_enable = 1, alu_source_select = 1, status_bit = 1, alu_operation = 0000, addressing_mode = 00, mem_enable = 0, pc_source_select = 0.
- Latch 0xE7D12000 (LDRB) -> reg_write_enable = 1, mem_enable = 1, mem_rw = 0, mem_to_reg_select = 1, mem_size = 1, alu_operation = 0100, alu_source_select = 0, addressing_mode = 01.
- Latch 0xE58A5000 (STR) -> reg_write_enable = 0, mem_enable = 1, mem_rw = 1, mem_size = 0, alu_source_select = 1, alu_operation = 0100, addressing_mode = 00.
- Latch 0xDB000009 (BLLE) -> pc_source_select = 1, reg_write_enable = 1, addressing_mode = 11. Latch 0x1AFFFFFD (BNE) -> pc_source_select = 1, reg_write_enable = 0.
- Latch 0xE0805183 (ADD), then raise hazard_select -> all muxed controls drop to 0 in the same cycle. addressing_mode = 01 without the macro, 00 with it. Then if_id_enable = 0 with new input -> instruction_out holds 0xE0805183.
